// File: rtl/tlc_pkg.sv
// Shared types, default timing constants and per-approach lamp decode for
// the traffic-light phase controller (flash feature gated by TLC_FLASH_EN).
package tlc_pkg;

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    FLASH  = 2'd3
  } phase_e;

  localparam int unsigned DEF_N_DIR        = 4;
  localparam int unsigned DEF_GREEN_TICKS  = 8;
  localparam int unsigned DEF_YELLOW_TICKS = 2;
  localparam int unsigned DEF_ALLRED_TICKS = 1;
  localparam int unsigned DEF_CNT_W        = 8;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  // Exactly one lamp per approach; only the owning approach leaves red.
  function automatic lamp_t lamp_decode(phase_e ph, logic is_active, logic blink);
    lamp_t l;
    l = '{red: 1'b1, yellow: 1'b0, green: 1'b0};
    case (ph)
      GREEN:   if (is_active) l = '{red: 1'b0, yellow: 1'b0, green: 1'b1};
      YELLOW:  if (is_active) l = '{red: 1'b0, yellow: 1'b1, green: 1'b0};
      FLASH:   l = '{red: 1'b0, yellow: blink, green: 1'b0};
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tlc_phase_ctrl_if.sv
// Request/lamp bundle between the traffic-light controller (slave) and its
// environment (master). flash_req is only consumed with TLC_FLASH_EN.
interface tlc_phase_ctrl_if
  import tlc_pkg::*;
#(
  parameter int unsigned N_DIR = DEF_N_DIR,
  parameter int unsigned DIR_W = $clog2(N_DIR)
) ();

  logic             tick_en;
  logic [N_DIR-1:0] car_req;
  logic             flash_req;
  logic [N_DIR-1:0] red;
  logic [N_DIR-1:0] yellow;
  logic [N_DIR-1:0] green;
  logic [DIR_W-1:0] active_dir;
  logic [1:0]       phase;

  modport master (
    output tick_en, car_req, flash_req,
    input  red, yellow, green, active_dir, phase
  );

  modport slave (
    input  tick_en, car_req, flash_req,
    output red, yellow, green, active_dir, phase
  );

endinterface

// File: rtl/tlc_rr_pick.sv
// Combinational round-robin picker: first set request at or after base_i,
// wrapping modulo N_DIR; idx_o falls back to base_i when nothing is set.
module tlc_rr_pick #(
  parameter int unsigned N_DIR = 4,
  parameter int unsigned DIR_W = $clog2(N_DIR)
) (
  input  logic [N_DIR-1:0] req_i,
  input  logic [DIR_W-1:0] base_i,
  output logic [DIR_W-1:0] idx_o,
  output logic             found_o
);

  int unsigned      cand;
  logic [DIR_W-1:0] cand_idx;

  always_comb begin
    idx_o    = base_i;
    found_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < N_DIR; i++) begin
      // base_i < N_DIR, so one conditional subtract is a full modulo
      cand = 32'(base_i) + i;
      if (cand >= N_DIR) cand = cand - N_DIR;
      cand_idx = DIR_W'(cand);
      if (!found_o && req_i[cand_idx]) begin
        idx_o   = cand_idx;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlc_phase_ctrl.sv
// Multi-approach traffic-light phase controller: GREEN -> YELLOW -> ALLRED
// round-robin with demand skipping and rest-in-green. Optional TLC_FLASH_EN.
module tlc_phase_ctrl
  import tlc_pkg::*;
#(
  parameter int unsigned N_DIR        = DEF_N_DIR,
  parameter int unsigned GREEN_TICKS  = DEF_GREEN_TICKS,
  parameter int unsigned YELLOW_TICKS = DEF_YELLOW_TICKS,
  parameter int unsigned ALLRED_TICKS = DEF_ALLRED_TICKS,
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned DIR_W        = $clog2(N_DIR)
) (
  input  logic           clk,
  input  logic           rst_n,
  tlc_phase_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] G_LD = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] Y_LD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] A_LD = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [DIR_W-1:0] LAST = DIR_W'(N_DIR - 1);

  phase_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [DIR_W-1:0] dir_q, dir_d;
  logic             blink_q, blink_d;

  logic             expire;
  logic [DIR_W-1:0] dir_next;
  logic [N_DIR-1:0] dir_mask;
  logic             leave_green;
  logic [DIR_W-1:0] pick_idx;
  logic             pick_found;
  lamp_t            lamp_w;

  assign expire   = bus.tick_en && (timer_q == '0);
  assign dir_next = (dir_q == LAST) ? '0 : dir_q + DIR_W'(1);
  assign dir_mask = N_DIR'(1) << dir_q;
  // Competing demand ends green; zero demand keeps the fixed-time rotation going.
  assign leave_green = (|(bus.car_req & ~dir_mask)) || (bus.car_req == '0);

  tlc_rr_pick #(
    .N_DIR(N_DIR),
    .DIR_W(DIR_W)
  ) u_pick (
    .req_i  (bus.car_req),
    .base_i (dir_next),
    .idx_o  (pick_idx),
    .found_o(pick_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ALLRED;
      timer_q <= A_LD;
      dir_q   <= LAST;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dir_q   <= dir_d;
      blink_q <= blink_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    blink_d = blink_q;
    if (bus.tick_en) timer_d = timer_q - CNT_W'(1);
    case (state_q)
      ALLRED: if (expire) begin
        state_d = GREEN;
        timer_d = G_LD;
        dir_d   = pick_found ? pick_idx : dir_next;
      end
      GREEN: if (expire) begin
        if (leave_green) begin
          state_d = YELLOW;
          timer_d = Y_LD;
        end else begin
          timer_d = G_LD;
        end
      end
      YELLOW: if (expire) begin
        state_d = ALLRED;
        timer_d = A_LD;
      end
      default: begin
`ifdef TLC_FLASH_EN
        timer_d = timer_q;
        if (bus.tick_en) blink_d = ~blink_q;
        if (!bus.flash_req) begin
          state_d = ALLRED;
          timer_d = A_LD;
          blink_d = 1'b0;
        end
`else
        state_d = ALLRED;
        timer_d = A_LD;
        blink_d = 1'b0;
`endif
      end
    endcase
`ifdef TLC_FLASH_EN
    if (bus.flash_req && (state_q != FLASH)) begin
      state_d = FLASH;
      timer_d = timer_q;
      dir_d   = dir_q;
      blink_d = 1'b0;
    end
`endif
  end

  always_comb begin
    bus.red    = '0;
    bus.yellow = '0;
    bus.green  = '0;
    lamp_w     = '0;
    for (int unsigned k = 0; k < N_DIR; k++) begin
      lamp_w        = lamp_decode(state_q, dir_q == DIR_W'(k), blink_q);
      bus.red[k]    = lamp_w.red;
      bus.yellow[k] = lamp_w.yellow;
      bus.green[k]  = lamp_w.green;
    end
  end

  assign bus.phase      = state_q;
  assign bus.active_dir = dir_q;

endmodule

// File: tb/tb_tlc_phase_ctrl.sv
// Scoreboard bench for tlc_phase_ctrl (default build, TLC_FLASH_EN undefined):
// a tick-counting model pushes expected lamp records, compared after each edge.
module tb_tlc_phase_ctrl;
  import tlc_pkg::*;

  localparam int N  = 4;
  localparam int GT = 8;
  localparam int YT = 2;
  localparam int AT = 1;

  logic clk = 1'b0;
  logic rst_n;

  tlc_phase_ctrl_if #(.N_DIR(N)) bus ();

  tlc_phase_ctrl #(
    .N_DIR       (N),
    .GREEN_TICKS (GT),
    .YELLOW_TICKS(YT),
    .ALLRED_TICKS(AT),
    .CNT_W       (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_ph, m_dir, m_left;
  logic [15:0] sb_q[$];
  int          order_q[$];
  logic [1:0]  prev_phase;
  logic        g1_seen;
  logic        hit;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_rec(int ph, int dir);
    logic [3:0] r, y, g;
    r = 4'b1111; y = 4'b0000; g = 4'b0000;
    if (ph == 1) begin r[dir] = 1'b0; g[dir] = 1'b1; end
    else if (ph == 2) begin r[dir] = 1'b0; y[dir] = 1'b1; end
    return {2'(ph), 2'(dir), r, y, g};
  endfunction

  function automatic logic [15:0] dut_rec();
    return {bus.phase, bus.active_dir, bus.red, bus.yellow, bus.green};
  endfunction

  task automatic model_reset();
    m_ph = 0; m_dir = N - 1; m_left = AT;
    prev_phase = 2'd0;
    g1_seen = 1'b0;
    order_q.delete();
    sb_q.delete();
  endtask

  task automatic model_edge(input logic tk);
    int d;
    logic [3:0] req;
    req = bus.car_req;
    if (!tk) return;
    m_left--;
    if (m_left != 0) return;
    case (m_ph)
      0: begin
        d = (m_dir + 1) % N;
        for (int j = 1; j <= N; j++)
          if (req[(m_dir + j) % N]) begin d = (m_dir + j) % N; break; end
        m_dir = d; m_ph = 1; m_left = GT;
      end
      1: begin
        if (req == 4'b0000 || (req & ~(4'b0001 << m_dir)) != 4'b0000) begin
          m_ph = 2; m_left = YT;
        end else m_left = GT;
      end
      default: begin m_ph = 0; m_left = AT; end
    endcase
  endtask

  task automatic step(input logic tk);
    logic [15:0] e;
    bus.tick_en = tk;
    model_edge(tk);
    sb_q.push_back(exp_rec(m_ph, m_dir));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) check("sb_underflow", 16'd0, 16'd1);
    else begin
      e = sb_q.pop_front();
      check("lamps", dut_rec(), e);
    end
    if (bus.phase == 2'd1 && prev_phase != 2'd1) order_q.push_back(int'(bus.active_dir));
    if (bus.green[1]) g1_seen = 1'b1;
    prev_phase = bus.phase;
    bus.tick_en = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int t = 0; t < n; t++) begin
      step(1'b0); step(1'b0); step(1'b0); step(1'b1);
    end
  endtask

  task automatic run_until_green(input string tag, input int d, input int budget);
    hit = 1'b0;
    for (int t = 0; t < budget && !hit; t++) begin
      run_ticks(1);
      if (bus.phase == 2'd1 && int'(bus.active_dir) == d) hit = 1'b1;
    end
    check(tag, 16'(hit), 16'd1);
  endtask

  task automatic check_order(input string tag);
    int exp_o[5];
    exp_o = '{0, 1, 2, 3, 0};
    check({tag, "_len"}, 16'(order_q.size() >= 5), 16'd1);
    for (int i = 0; i < 5; i++)
      if (i < order_q.size()) check(tag, 16'(order_q[i]), 16'(exp_o[i]));
  endtask

  task automatic reset_release();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.tick_en = 1'b0;
    bus.car_req = 4'b1111;
    bus.flash_req = 1'b0;
    #12;
    check("reset_state", dut_rec(), {2'd0, 2'd3, 4'b1111, 4'b0000, 4'b0000});
    reset_release();

    // full rotation with all approaches demanding
    run_ticks(1);
    check("first_green", dut_rec(), exp_rec(1, 0));
    run_ticks(84);
    check_order("order_full");
    check("mid_green3", {14'd0, bus.phase}, 16'd1);

    // asynchronous reset mid-green
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", dut_rec(), {2'd0, 2'd3, 4'b1111, 4'b0000, 4'b0000});
    reset_release();

    // demand skipping
    run_until_green("wait_g0", 0, 4);
    bus.car_req = 4'b0100;
    g1_seen = 1'b0;
    run_until_green("wait_g2", 2, 20);
    check("skip_no_g1", 16'(g1_seen), 16'd0);

    // rest in green, then competing demand
    bus.car_req = 4'b0010;
    run_until_green("wait_g1", 1, 20);
    run_ticks(3 * GT);
    check("rest_green", {12'd0, bus.green}, 16'h0002);
    check("rest_phase", {14'd0, bus.phase}, 16'd1);
    bus.car_req = 4'b1010;
    run_ticks(GT);
    check("yellow_after", dut_rec(), exp_rec(2, 1));
    run_until_green("wait_g3", 3, 6);

    // no demand: fixed-time rotation; flash_req ignored in this build
    rst_n = 1'b0;
    bus.car_req = 4'b0000;
`ifndef TLC_FLASH_EN
    bus.flash_req = 1'b1;
`endif
    #1;
    check("reset2", dut_rec(), {2'd0, 2'd3, 4'b1111, 4'b0000, 4'b0000});
    reset_release();
    run_ticks(88);
    check_order("order_nodemand");
    check("nodemand_len", 16'(order_q.size()), 16'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
